mw_time_entry_countdown: RTL and testbench

Microwave time-entry and countdown block. It assembles keypad BCD digits into a 4-digit MM:SS value and, on start, counts that value down once per second. It supports pause, resume and clear. It presents the live 16-bit BCD word that the microwave's 4-digit equality comparator consumes, and pulses `done` when the countdown reaches 00:00.

---
 rtl/mw_time_entry_countdown.sv | 159 +++++++++++++++
 tb/tb_mw_time_entry_countdown.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mw_time_entry_countdown.sv
// Microwave time entry and countdown.
// Keypad digits shift into a 4-digit BCD MM:SS word. On start the word counts
// down once per second using a BCD borrow chain; pause, resume and clear are
// supported. done pulses for one cycle when the countdown reaches 00:00.
module mw_time_entry_countdown #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_start,
  input  logic        key_clear,
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        paused,
  output logic        done,
  output logic        start_err
);

  localparam int unsigned PscW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PscW-1:0] PscLast = PscW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPaused
  } state_e;

  state_e          state_q, state_d;
  logic [PscW-1:0] psc_q, psc_d;
  logic [15:0]     time_q, time_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [15:0]     dec_val;
  logic            digit_ok;
  logic            start_ok;

  // One-second BCD decrement; every digit handled as its own 4-bit field.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
    m10 = v[15:12];
    m1  = v[11:8];
    s10 = v[7:4];
    s1  = v[3:0];
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = 4'd5;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1  = 4'd9;
          m10 = m10 - 4'd1;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  // Decoded helpers shared by the next-state logic.
  always_comb begin
    dec_val  = bcd_dec(time_q);
    digit_ok = key_valid && (key_digit <= 4'd9);
    // Seconds-tens above 5 is not a valid MM:SS value to count from.
    start_ok = (time_q[7:4] <= 4'd5);
  end

  // Next-state logic: clear beats start beats digit entry in every state.
  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    time_d  = time_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_clear) begin
          time_d = '0;
          psc_d  = '0;
        end else if (key_start) begin
          // A zero value ignores start silently.
          if (time_q != 16'h0000) begin
            if (start_ok) begin
              state_d = StRun;
              psc_d   = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (digit_ok) begin
          time_d = {time_q[11:0], key_digit};
        end
      end
      StRun: begin
        if (key_clear) begin
          state_d = StIdle;
          time_d  = '0;
          psc_d   = '0;
        end else if (key_start) begin
          // Pause freezes the prescaler, so a terminal count stays pending.
          state_d = StPaused;
        end else if (psc_q == PscLast) begin
          psc_d  = '0;
          time_d = dec_val;
          if (dec_val == 16'h0000) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          psc_d = psc_q + PscW'(1);
        end
      end
      StPaused: begin
        if (key_clear) begin
          state_d = StIdle;
          time_d  = '0;
          psc_d   = '0;
        end else if (key_start) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      psc_q   <= '0;
      time_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      time_q  <= time_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign time_bcd  = time_q;
  assign running   = (state_q == StRun);
  assign paused    = (state_q == StPaused);
  assign done      = done_q;
  assign start_err = err_q;

endmodule

// File: tb/tb_mw_time_entry_countdown.sv
// Bench for mw_time_entry_countdown: directed steps followed by random
// keypad traffic, all checked against a seconds-based reference model.
module tb_mw_time_entry_countdown;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        key_start = 1'b0;
  logic        key_clear = 1'b0;
  logic [15:0] time_bcd;
  logic        running;
  logic        paused;
  logic        done;
  logic        start_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: state 0 idle, 1 run, 2 paused; value kept as a decimal number MMSS.
  int   m_state = 0;
  int   m_psc = 0;
  int   m_val = 0;
  logic m_done = 1'b0;
  logic m_err = 1'b0;

  always #5 clk = ~clk;

  mw_time_entry_countdown #(
    .TICKS_PER_SEC(T)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_digit(key_digit),
    .key_start(key_start),
    .key_clear(key_clear),
    .time_bcd (time_bcd),
    .running  (running),
    .paused   (paused),
    .done     (done),
    .start_err(start_err)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int to_secs(input int v);
    return (v / 100) * 60 + (v % 100);
  endfunction

  function automatic int from_secs(input int s);
    return (s / 60) * 100 + (s % 60);
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour for one clock edge, from the inputs applied to it.
  task automatic model();
    int s;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_state = 0;
      m_psc   = 0;
      m_val   = 0;
    end else if (m_state == 0) begin
      if (key_clear) m_val = 0;
      else if (key_start) begin
        if (m_val != 0) begin
          if ((m_val / 10) % 10 > 5) m_err = 1'b1;
          else begin
            m_state = 1;
            m_psc   = 0;
          end
        end
      end else if (key_valid && key_digit <= 4'd9) begin
        m_val = (m_val % 1000) * 10 + int'(key_digit);
      end
    end else if (key_clear) begin
      m_state = 0;
      m_val   = 0;
      m_psc   = 0;
    end else if (key_start) begin
      m_state = (m_state == 1) ? 2 : 1;
    end else if (m_state == 1) begin
      if (m_psc == T - 1) begin
        m_psc = 0;
        s     = to_secs(m_val) - 1;
        m_val = from_secs(s);
        if (s == 0) begin
          m_state = 0;
          m_done  = 1'b1;
        end
      end else begin
        m_psc++;
      end
    end
  endtask

  // One clock: apply the staged inputs, update the model, compare, release strobes.
  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("time_bcd", time_bcd, to_bcd(m_val));
    chk("running", 16'(running), 16'(m_state == 1));
    chk("paused", 16'(paused), 16'(m_state == 2));
    chk("done", 16'(done), 16'(m_done));
    chk("start_err", 16'(start_err), 16'(m_err));
    rst       = 1'b0;
    key_valid = 1'b0;
    key_start = 1'b0;
    key_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
  endtask

  task automatic do_start();
    key_start = 1'b1;
    step();
  endtask

  task automatic do_clear();
    key_clear = 1'b1;
    step();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    chk("reset_time", time_bcd, 16'h0000);
    chk("reset_flags", 16'({running, paused, done, start_err}), 16'h0);

    // Entry and digit overflow
    press(4'd1); press(4'd2); press(4'd3); press(4'd0);
    chk("entry_1230", time_bcd, 16'h1230);
    press(4'd5);
    chk("entry_fifth", time_bcd, 16'h2305);
    press(4'd12);
    chk("entry_bad_digit", time_bcd, 16'h2305);

    // Countdown with borrow from 01:00
    do_clear();
    press(4'd0); press(4'd1); press(4'd0); press(4'd0);
    do_start();
    chk("start_running", 16'(running), 16'h1);
    idle(4);
    chk("borrow_0059", time_bcd, 16'h0059);
    idle(235);
    chk("before_zero", time_bcd, 16'h0001);
    step();
    chk("zero_time", time_bcd, 16'h0000);
    chk("zero_done", 16'(done), 16'h1);
    chk("zero_running", 16'(running), 16'h0);
    step();
    chk("done_drops", 16'(done), 16'h0);

    // Start validation
    press(4'd0); press(4'd0); press(4'd7); press(4'd0);
    do_start();
    chk("err_pulse", 16'(start_err), 16'h1);
    chk("err_idle", 16'(running), 16'h0);
    chk("err_value", time_bcd, 16'h0070);
    step();
    chk("err_clears", 16'(start_err), 16'h0);
    do_clear();
    do_start();
    chk("zero_start_err", 16'(start_err), 16'h0);
    chk("zero_start_run", 16'(running), 16'h0);

    // Pause and resume from 00:05
    press(4'd0); press(4'd0); press(4'd0); press(4'd5);
    do_start();
    idle(2);
    do_start();
    chk("pause_flag", 16'(paused), 16'h1);
    idle(20);
    chk("pause_frozen", time_bcd, 16'h0005);
    do_start();
    step();
    chk("resume_hold", time_bcd, 16'h0005);
    step();
    chk("resume_dec", time_bcd, 16'h0004);
    do_clear();

    // Clear with start in the same cycle while running
    press(4'd3);
    do_start();
    idle(2);
    key_clear = 1'b1;
    key_start = 1'b1;
    step();
    chk("clr_start_time", time_bcd, 16'h0000);
    chk("clr_start_state", 16'({running, paused, done}), 16'h0);

    // Digit with start in idle: start uses the old value
    press(4'd4);
    key_valid = 1'b1;
    key_digit = 4'd7;
    do_start();
    chk("valid_start_val", time_bcd, 16'h0004);
    chk("valid_start_run", 16'(running), 16'h1);
    do_clear();

    // Pause on terminal count, resume fires the pending decrement at once
    press(4'd2);
    do_start();
    idle(3);
    do_start();
    chk("tc_pause_val", time_bcd, 16'h0002);
    idle(5);
    do_start();
    step();
    chk("tc_resume_dec", time_bcd, 16'h0001);
    idle(2);
    do_clear();
    chk("tc_clear_time", time_bcd, 16'h0000);
    chk("tc_clear_done", 16'(done), 16'h0);

    // Reset mid-run at 03:42
    press(4'd0); press(4'd3); press(4'd4); press(4'd2);
    do_start();
    idle(1);
    rst = 1'b1;
    step();
    chk("rst_time", time_bcd, 16'h0000);
    chk("rst_flags", 16'({running, paused, done, start_err}), 16'h0);
    press(4'd9);
    chk("rst_entry", time_bcd, 16'h0009);

    // Random keypad traffic
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      key_clear = ($urandom_range(0, 99) < 2);
      key_start = ($urandom_range(0, 99) < 6);
      key_valid = ($urandom_range(0, 99) < 35);
      key_digit = 4'($urandom_range(0, 15));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
